// File: rtl/ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ext_pkg
// Description : Shared mode encodings for the immediate-extension unit.
// Revision    : 1.0 - initial release
// ============================================================================
package ext_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] EXT_SEXT     = 2'b00;
    localparam logic [MODE_W-1:0] EXT_ZEXT     = 2'b01;
    localparam logic [MODE_W-1:0] EXT_UPPER    = 2'b10;
    localparam logic [MODE_W-1:0] EXT_SEXT_SHL = 2'b11;

endpackage
`default_nettype wire

// File: rtl/ext_core.sv
`default_nettype none
// ============================================================================
// Module      : ext_core
// Description : Combinational immediate widener (sign/zero/upper/sign+shift).
// Revision    : 1.0 - initial release
// ============================================================================
module ext_core
    import ext_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic [IN_W-1:0]   data_i,
    input  logic [MODE_W-1:0] mode_i,
    output logic [OUT_W-1:0]  ext_o
);

    localparam int E = OUT_W - IN_W;

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_zext;
    logic [OUT_W-1:0] w_upper;
    logic [OUT_W-1:0] w_sext_shl;

    assign w_sext     = {{E{data_i[IN_W-1]}}, data_i};
    assign w_zext     = {{E{1'b0}}, data_i};
    assign w_upper    = {data_i, {E{1'b0}}};
    // Bits pushed past the MSB are dropped by the fixed-width result.
    assign w_sext_shl = w_sext << BR_SHIFT;

    always_comb begin
        ext_o = w_sext;
        case (mode_i)
            EXT_SEXT:     ext_o = w_sext;
            EXT_ZEXT:     ext_o = w_zext;
            EXT_UPPER:    ext_o = w_upper;
            EXT_SEXT_SHL: ext_o = w_sext_shl;
            default:      ext_o = w_sext;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ext_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module      : ext_pipe_unit
// Description : Registered immediate extender with a 2-entry handshake queue.
// Revision    : 1.0 - initial release
// ============================================================================
module ext_pipe_unit
    import ext_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [IN_W-1:0]   data_i,
    input  logic [MODE_W-1:0] mode_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [OUT_W-1:0]  data_o,
    output logic [1:0]        count_o
);

    logic [OUT_W-1:0] r_mem [2];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_count;

    logic [OUT_W-1:0] w_ext;
    logic             w_push;
    logic             w_pop;

    ext_core #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .BR_SHIFT (BR_SHIFT)
    ) u_core (
        .data_i (data_i),
        .mode_i (mode_i),
        .ext_o  (w_ext)
    );

    // Handshake outputs derive from registered occupancy only.
    assign ready_o = (r_count != 2'd2);
    assign valid_o = (r_count != 2'd0);
    assign count_o = r_count;
    assign data_o  = valid_o ? r_mem[r_rd_ptr] : '0;

    assign w_push = valid_i && ready_o;
    assign w_pop  = valid_o && ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count  <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_ext;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ext_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ext_pipe_unit
// Description : Directed, table-driven self-checking bench for ext_pipe_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_pipe_unit;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        ready_out;
    logic [15:0] data_in;
    logic [1:0]  mode_in;
    logic        valid_out;
    logic        ready_in;
    logic [31:0] data_out;
    logic [1:0]  count_out;

    int checks_total;
    int checks_passed;

    ext_pipe_unit #(
        .IN_W     (16),
        .OUT_W    (32),
        .BR_SHIFT (2)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .valid_i (valid_in),
        .ready_o (ready_out),
        .data_i  (data_in),
        .mode_i  (mode_in),
        .valid_o (valid_out),
        .ready_i (ready_in),
        .data_o  (data_out),
        .count_o (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] din;
        logic [31:0] expect_data;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " valid_o"}, {31'd0, valid_out}, 32'd0);
        chk({tag, " data_o"},  data_out, 32'd0);
        chk({tag, " count_o"}, {30'd0, count_out}, 32'd0);
        chk({tag, " ready_o"}, {31'd0, ready_out}, 32'd1);
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;

        vecs[0] = '{2'b00, 16'h8001, 32'hFFFF8001};
        vecs[1] = '{2'b01, 16'h8001, 32'h00008001};
        vecs[2] = '{2'b10, 16'h1234, 32'h12340000};
        vecs[3] = '{2'b11, 16'hFFFF, 32'hFFFFFFFC};
        vecs[4] = '{2'b11, 16'h4000, 32'h00010000};
        vecs[5] = '{2'b00, 16'h7FFF, 32'h00007FFF};
        vecs[6] = '{2'b10, 16'hFFFF, 32'hFFFF0000};

        rst      = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b0;
        data_in  = '0;
        mode_in  = 2'b00;

        // Reset
        tick();
        tick();
        rst = 1'b0;
        chk_idle("reset");

        // Modes: one word per cycle, consumed the cycle after it appears
        ready_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            valid_in = 1'b1;
            mode_in  = vecs[i].mode;
            data_in  = vecs[i].din;
            tick();
            valid_in = 1'b0;
            data_in  = 16'hDEAD;
            chk($sformatf("mode%0d valid_o", i), {31'd0, valid_out}, 32'd1);
            chk($sformatf("mode%0d data_o", i), data_out, vecs[i].expect_data);
            chk($sformatf("mode%0d count_o", i), {30'd0, count_out}, 32'd1);
            tick();
            chk($sformatf("mode%0d drained", i), {30'd0, count_out}, 32'd0);
        end

        // Backpressure
        ready_in = 1'b0;
        mode_in  = 2'b00;
        valid_in = 1'b1;
        data_in  = 16'h0001;
        tick();
        chk("bp count1", {30'd0, count_out}, 32'd1);
        data_in = 16'h0002;
        tick();
        chk("bp count2", {30'd0, count_out}, 32'd2);
        chk("bp ready_o full", {31'd0, ready_out}, 32'd0);
        chk("bp head1", data_out, 32'h1);
        data_in = 16'h0003;
        tick();
        chk("bp no overwrite count", {30'd0, count_out}, 32'd2);
        chk("bp no overwrite head", data_out, 32'h1);
        ready_in = 1'b1;
        tick();
        chk("bp pop head2", data_out, 32'h2);
        chk("bp pop count", {30'd0, count_out}, 32'd1);
        chk("bp ready_o back", {31'd0, ready_out}, 32'd1);
        tick();
        chk("bp third accepted", data_out, 32'h3);
        chk("bp third count", {30'd0, count_out}, 32'd1);
        valid_in = 1'b0;
        tick();
        chk("bp drained", {30'd0, count_out}, 32'd0);

        // Streaming: 8 words back-to-back with pointers wrapping
        ready_in = 1'b1;
        mode_in  = 2'b00;
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'b1;
            data_in  = 16'(i);
            tick();
            chk($sformatf("stream%0d valid_o", i), {31'd0, valid_out}, 32'd1);
            chk($sformatf("stream%0d data_o", i), data_out, 32'(i));
            chk($sformatf("stream%0d count_o", i), {30'd0, count_out}, 32'd1);
        end
        valid_in = 1'b0;
        tick();
        chk("stream drained", {30'd0, count_out}, 32'd0);

        // Simultaneous push/pop at count=1
        ready_in = 1'b0;
        valid_in = 1'b1;
        mode_in  = 2'b00;
        data_in  = 16'h0005;
        tick();
        chk("pp older head", data_out, 32'h5);
        ready_in = 1'b1;
        mode_in  = 2'b01;
        data_in  = 16'hFFFF;
        tick();
        valid_in = 1'b0;
        chk("pp count held", {30'd0, count_out}, 32'd1);
        chk("pp newer head", data_out, 32'h0000FFFF);
        tick();
        chk("pp drained", {30'd0, count_out}, 32'd0);

        // Reset while full, with push and pop requested
        ready_in = 1'b0;
        valid_in = 1'b1;
        mode_in  = 2'b01;
        data_in  = 16'h00AA;
        tick();
        data_in = 16'h00BB;
        tick();
        chk("rst_mid full", {30'd0, count_out}, 32'd2);
        rst      = 1'b1;
        ready_in = 1'b1;
        data_in  = 16'h00CC;
        tick();
        chk_idle("rst_mid");
        rst      = 1'b0;
        valid_in = 1'b0;
        tick();
        tick();
        chk_idle("rst_mid after");
        valid_in = 1'b1;
        data_in  = 16'h0077;
        tick();
        valid_in = 1'b0;
        chk("rst_mid fresh word", data_out, 32'h00000077);
        chk("rst_mid fresh count", {30'd0, count_out}, 32'd1);
        tick();
        chk("rst_mid no stale", {31'd0, valid_out}, 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
`default_nettype wire
